dac_spi_sequencer: RTL

DAC_SPI_SEQUENCER -- requirements
Module: dac_spi_sequencer

---
 rtl/dac_spi_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dac_spi_sequencer.sv
// Streams one FRAME_BITS word MSB-first to a DAC in SPI mode 0, then an optional ldac_n load pulse.
// Latency: SS_n falls the cycle after accept; wr_ready is low from accept until the FSM is back in IDLE (no queuing).
module dac_spi_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 24,
    parameter int LDAC_WIDTH = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [FRAME_BITS-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  spi_SCLK,
    output logic                  spi_MOSI,
    output logic                  spi_SS_n,
    output logic                  ldac_n,
    output logic                  busy
);

    localparam int CNT_MAX = (CLK_DIV > LDAC_WIDTH) ? CLK_DIV : LDAC_WIDTH;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC} state_t;

    state_t                  state_q;
    logic [FRAME_BITS-1:0]   shreg_q;
    logic                    last_q;
    logic [BIT_W-1:0]        bit_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ss_n_q;
    logic                    sclk_q;
    logic                    mosi_q;
    logic                    ldac_n_q;
    logic                    busy_q;
    logic                    rdy_q;

    // shreg_q holds the bits still to be presented; its MSB is the next bit after the current one.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            last_q   <= 1'b0;
            bit_q    <= '0;
            cnt_q    <= '0;
            ss_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            ldac_n_q <= 1'b1;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (wr_valid && rdy_q) begin
                        shreg_q <= wr_data << 1;
                        mosi_q  <= wr_data[FRAME_BITS-1];
                        last_q  <= wr_last;
                        bit_q   <= '0;
                        cnt_q   <= '0;
                        ss_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                                ss_n_q  <= 1'b1;
                                mosi_q  <= 1'b0;
                                state_q <= GAP;
                            end else begin
                                bit_q   <= bit_q + BIT_W'(1);
                                mosi_q  <= shreg_q[FRAME_BITS-1];
                                shreg_q <= shreg_q << 1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_q <= '0;
                        if (last_q) begin
                            ldac_n_q <= 1'b0;
                            state_q  <= LDAC;
                        end else begin
                            busy_q  <= 1'b0;
                            rdy_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LDAC: begin
                    if (cnt_q == CNT_W'(LDAC_WIDTH - 1)) begin
                        cnt_q    <= '0;
                        ldac_n_q <= 1'b1;
                        busy_q   <= 1'b0;
                        rdy_q    <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ready = rdy_q;
    assign spi_SCLK = sclk_q;
    assign spi_MOSI = mosi_q;
    assign spi_SS_n = ss_n_q;
    assign ldac_n   = ldac_n_q;
    assign busy     = busy_q;

endmodule
